// File: rtl/uart_rx_chunker.sv
// Collects bytes from a UART receiver into fixed-size chunks. A chunk closes when it
// is full or after TIMEOUT_TICKS idle cycles, and is held until the consumer acks it.
module uart_rx_chunker #(
    parameter int BUFFER_BYTE_SIZE  = 3,
    parameter int BUFFER_INDEX_SIZE = 32,
    parameter int TIMEOUT_TICKS     = 1000000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          rx_ready,
    input  logic [7:0]                    rx_data,
    input  logic                          chunk_ack,
    output logic                          is_chunk_ready,
    output logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
    output logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
    output logic                          is_overflow,
    output logic [1:0]                    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } state_t;

    localparam logic [BUFFER_INDEX_SIZE-1:0] FULL_COUNT = BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE);
    localparam logic [BUFFER_INDEX_SIZE-1:0] ONE_COUNT  = BUFFER_INDEX_SIZE'(1);
    localparam logic [31:0]                  TIMER_LAST = 32'(TIMEOUT_TICKS - 1);

    state_t                          r_state;
    logic [BUFFER_INDEX_SIZE-1:0]    r_count;
    logic [BUFFER_BYTE_SIZE*8-1:0]   r_buf;
    logic [31:0]                     r_timer;
    logic                            r_overflow;

    state_t                          w_state_n;
    logic [BUFFER_INDEX_SIZE-1:0]    w_count_n;
    logic [BUFFER_BYTE_SIZE*8-1:0]   w_buf_n;
    logic [31:0]                     w_timer_n;
    logic                            w_overflow_n;
    logic                            w_take;
    logic [BUFFER_INDEX_SIZE-1:0]    w_base_count;
    logic [BUFFER_BYTE_SIZE*8-1:0]   w_base_buf;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_buf      <= '0;
            r_timer    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_count    <= w_count_n;
            r_buf      <= w_buf_n;
            r_timer    <= w_timer_n;
            r_overflow <= w_overflow_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_count_n    = r_count;
        w_buf_n      = r_buf;
        w_timer_n    = r_timer;
        w_overflow_n = 1'b0;
        w_take       = 1'b0;
        w_base_count = r_count;
        w_base_buf   = r_buf;

        case (r_state)
            IDLE: begin
                w_timer_n = '0;
                w_take    = rx_ready;
            end
            COLLECT: begin
                if (rx_ready) begin
                    w_take = 1'b1;
                end else if (TIMEOUT_TICKS > 0) begin
                    // Timer saturates one below the limit: that cycle closes the chunk.
                    if (r_timer >= TIMER_LAST) begin
                        w_state_n = READY;
                        w_timer_n = '0;
                    end else begin
                        w_timer_n = r_timer + 32'd1;
                    end
                end
            end
            READY: begin
                if (chunk_ack) begin
                    // Ack wins over a coincident byte, which then starts a fresh chunk.
                    w_base_count = '0;
                    w_base_buf   = '0;
                    w_count_n    = '0;
                    w_buf_n      = '0;
                    w_timer_n    = '0;
                    w_state_n    = IDLE;
                    w_take       = rx_ready;
                end else if (rx_ready) begin
                    w_overflow_n = 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_count_n = '0;
                w_buf_n   = '0;
                w_timer_n = '0;
            end
        endcase

        if (w_take) begin
            w_buf_n = w_base_buf;
            for (int k = 0; k < BUFFER_BYTE_SIZE; k++) begin
                if (w_base_count == BUFFER_INDEX_SIZE'(k)) begin
                    w_buf_n[8*k +: 8] = rx_data;
                end
            end
            w_count_n = w_base_count + ONE_COUNT;
            w_timer_n = '0;
            w_state_n = (w_base_count + ONE_COUNT == FULL_COUNT) ? READY : COLLECT;
        end
    end

    assign is_chunk_ready  = (r_state == READY);
    assign chunk_byte_size = r_count;
    assign chunk_bytes     = r_buf;
    assign is_overflow     = r_overflow;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_uart_rx_chunker.sv
// Bench for uart_rx_chunker: table of chunks (full and timed-out) checked through an
// expected queue, plus hand-written overflow, ack/rx collision, reset and no-timeout cases.
module tb_uart_rx_chunker;

    logic        clk;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        chunk_ack;

    logic        a_ready;
    logic [31:0] a_size;
    logic [23:0] a_bytes;
    logic        a_ovf;
    logic [1:0]  a_state;

    logic        b_ready;
    logic [31:0] b_size;
    logic [23:0] b_bytes;
    logic        b_ovf;
    logic [1:0]  b_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    uart_rx_chunker #(.BUFFER_BYTE_SIZE(3), .BUFFER_INDEX_SIZE(32), .TIMEOUT_TICKS(20)) dut_a (
        .CLK(clk), .RST(rst), .rx_ready(rx_ready), .rx_data(rx_data), .chunk_ack(chunk_ack),
        .is_chunk_ready(a_ready), .chunk_byte_size(a_size), .chunk_bytes(a_bytes),
        .is_overflow(a_ovf), .dbg_state(a_state)
    );

    uart_rx_chunker #(.BUFFER_BYTE_SIZE(3), .BUFFER_INDEX_SIZE(32), .TIMEOUT_TICKS(0)) dut_b (
        .CLK(clk), .RST(rst), .rx_ready(rx_ready), .rx_data(rx_data), .chunk_ack(chunk_ack),
        .is_chunk_ready(b_ready), .chunk_byte_size(b_size), .chunk_bytes(b_bytes),
        .is_overflow(b_ovf), .dbg_state(b_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic ack();
        chunk_ack = 1'b1;
        tick();
        chunk_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int          n;
        int          gap;
        logic [7:0]  d [3];
        logic [7:0]  exp_size;
        logic [23:0] exp_bytes;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] exp_w;
        int          lat;
        int          bad;

        rst       = 1'b1;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        chunk_ack = 1'b0;

        vecs[0] = '{n: 3, gap: 10, d: '{8'h41, 8'h42, 8'h43}, exp_size: 8'd3, exp_bytes: 24'h434241, exp_lat: 0};
        vecs[1] = '{n: 1, gap: 10, d: '{8'h7F, 8'h00, 8'h00}, exp_size: 8'd1, exp_bytes: 24'h00007F, exp_lat: 20};
        vecs[2] = '{n: 2, gap: 5,  d: '{8'hA5, 8'h5A, 8'h00}, exp_size: 8'd2, exp_bytes: 24'h005AA5, exp_lat: 20};
        vecs[3] = '{n: 3, gap: 20, d: '{8'h01, 8'h02, 8'h03}, exp_size: 8'd3, exp_bytes: 24'h030201, exp_lat: 0};
        vecs[4] = '{n: 2, gap: 19, d: '{8'hFF, 8'h00, 8'h00}, exp_size: 8'd2, exp_bytes: 24'h0000FF, exp_lat: 20};
        vecs[5] = '{n: 3, gap: 1,  d: '{8'hDE, 8'hAD, 8'hBE}, exp_size: 8'd3, exp_bytes: 24'hBEADDE, exp_lat: 0};

        repeat (3) tick();
        rst = 1'b0;
        chk("reset_ready", {63'd0, a_ready}, 64'd0);
        chk("reset_size",  {32'd0, a_size},  64'd0);
        chk("reset_bytes", {40'd0, a_bytes}, 64'd0);
        chk("reset_ovf",   {63'd0, a_ovf},   64'd0);

        // Table-driven chunks
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                if (i > 0) repeat (vecs[v].gap - 1) tick();
                chk($sformatf("v%0d_not_ready_b%0d", v, i), {63'd0, a_ready}, 64'd0);
                send_byte(vecs[v].d[i]);
            end
            exp_q.push_back({vecs[v].exp_size, vecs[v].exp_bytes});
            lat = 0;
            while (!a_ready && lat < 40) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            if (a_ready && exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                chk($sformatf("v%0d_chunk", v), {32'd0, a_size[7:0], a_bytes}, {32'd0, exp_w});
            end
            ack();
            chk($sformatf("v%0d_ack_clear", v), {31'd0, a_ready, a_size}, 64'd0);
            chk($sformatf("v%0d_ack_bytes", v), {40'd0, a_bytes}, 64'd0);
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        // Timeout edge: not ready at n+20, ready at n+21
        do_reset();
        send_byte(8'h7F);
        repeat (19) tick();
        chk("to_n20_not_ready", {63'd0, a_ready}, 64'd0);
        tick();
        chk("to_n21_ready", {63'd0, a_ready}, 64'd1);
        chk("to_chunk", {32'd0, a_size[7:0], a_bytes}, {32'd0, 8'd1, 24'h00007F});
        ack();

        // Overflow while holding a chunk
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("ovf_idle_before", {63'd0, a_ovf}, 64'd0);
        send_byte(8'h55);
        chk("ovf_pulse", {63'd0, a_ovf}, 64'd1);
        chk("ovf_chunk_kept", {31'd0, a_ready, a_size[7:0], a_bytes}, {31'd0, 1'b1, 8'd3, 24'h332211});
        tick();
        chk("ovf_one_cycle", {63'd0, a_ovf}, 64'd0);
        chk("ovf_still_ready", {63'd0, a_ready}, 64'd1);

        // Ack and byte in the same cycle
        chunk_ack = 1'b1;
        rx_ready  = 1'b1;
        rx_data   = 8'h10;
        tick();
        chunk_ack = 1'b0;
        rx_ready  = 1'b0;
        chk("ackrx_chunk", {31'd0, a_ready, a_size[7:0], a_bytes}, {31'd0, 1'b0, 8'd1, 24'h000010});
        chk("ackrx_no_ovf", {63'd0, a_ovf}, 64'd0);
        chk("ackrx_collect", {62'd0, a_state}, 64'd1);

        // Reset after two bytes, with rx and ack asserted in the reset cycle
        do_reset();
        send_byte(8'hA1);
        send_byte(8'hA2);
        rst       = 1'b1;
        rx_ready  = 1'b1;
        rx_data   = 8'h77;
        chunk_ack = 1'b1;
        tick();
        rst       = 1'b0;
        rx_ready  = 1'b0;
        chunk_ack = 1'b0;
        chk("rst_mid_outputs", {30'd0, a_ready, a_ovf, a_size}, 64'd0);
        chk("rst_mid_bytes", {40'd0, a_bytes}, 64'd0);
        send_byte(8'h99);
        chk("rst_first_slot0", {32'd0, a_size[7:0], a_bytes}, {32'd0, 8'd1, 24'h000099});

        // Timeout disabled: one byte then a long idle stretch
        do_reset();
        send_byte(8'h5A);
        bad = 0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (b_ready) bad++;
        end
        chk("notimeout_never_ready", 64'(bad), 64'd0);
        chk("notimeout_chunk", {32'd0, b_size[7:0], b_bytes}, {32'd0, 8'd1, 24'h00005A});
        chk("notimeout_state", {61'd0, b_ovf, b_state}, 64'd1);
        chk("timeout_a_closed", {63'd0, a_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_chunker.md
UART_RX_CHUNKER -- requirements
Module: uart_rx_chunker

Interface
REQ-001 SHALL have parameter BUFFER_BYTE_SIZE, default 3, meaning the maximum number of bytes per chunk (minimum 1).
REQ-002 SHALL have parameter BUFFER_INDEX_SIZE, default 32, meaning the width of the byte-count output.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 1000000, meaning the number of idle CLK cycles after which a partial chunk is closed; 0 disables the timeout.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_ready  input  1  one-cycle strobe from uart_rx: rx_data valid.
REQ-007 SHALL have port rx_data  input  8  received byte.
REQ-008 SHALL have port chunk_ack  input  1  consumer has taken the chunk; sampled only in READY.
REQ-009 SHALL have port is_chunk_ready  output  1  chunk complete and held stable.
REQ-010 SHALL have port chunk_byte_size  output  BUFFER_INDEX_SIZE  valid byte count of the chunk.
REQ-011 SHALL have port chunk_bytes  output  BUFFER_BYTE_SIZE*8  packed chunk; byte k at bits [8k+7:8k].
REQ-012 SHALL have port is_overflow  output  1  one-cycle pulse: a byte was dropped.

Function
REQ-013 SHALL implement the states IDLE (empty), COLLECT (1..BUFFER_BYTE_SIZE-1 bytes stored) and READY (chunk held).
REQ-014 SHALL, when rx_ready is high in cycle n (IDLE or COLLECT), write rx_data to byte slot [count], increment count and reset the idle timer; the result is visible on chunk_bytes/chunk_byte_size in cycle n+1.
REQ-015 SHALL, when the byte taken in cycle n makes count equal BUFFER_BYTE_SIZE, enter READY with is_chunk_ready=1 from cycle n+1 (BUFFER_BYTE_SIZE=1: IDLE goes directly to READY).
REQ-016 SHALL, in IDLE with no rx_ready, remain in IDLE with the idle timer not running.
REQ-017 SHALL, in COLLECT, increment the idle timer every cycle without rx_ready; with TIMEOUT_TICKS>0, if the last byte arrived in cycle n and no further byte arrives, enter READY with is_chunk_ready=1 in cycle n+1+TIMEOUT_TICKS and chunk_byte_size equal to the partial count.
REQ-018 SHALL hold the timer below TIMEOUT_TICKS so it never wraps; rx_ready in the closing cycle takes precedence: the byte is stored and the chunk is closed only if it is now full.
REQ-019 SHALL, in READY, hold chunk_bytes, chunk_byte_size and is_chunk_ready=1 unchanged until chunk_ack is sampled high.
REQ-020 SHALL, on chunk_ack high in READY, clear the buffer to zero and count to 0, and enter IDLE in the next cycle (is_chunk_ready=0).
REQ-021 SHALL, on rx_ready in READY without chunk_ack, drop the byte and pulse is_overflow for exactly cycle n+1; the chunk is unchanged.
REQ-022 SHALL, when chunk_ack and rx_ready coincide in READY, give the ack priority: the buffer is cleared, the new byte is stored in slot 0, count=1, the state becomes COLLECT (READY if BUFFER_BYTE_SIZE=1), and no overflow occurs.
REQ-023 SHALL ignore chunk_ack outside READY.
REQ-024 SHALL keep byte slots at index >= chunk_byte_size at zero at all times.
REQ-025 SHALL compare count against BUFFER_BYTE_SIZE at BUFFER_INDEX_SIZE width, with no overflow of count.

Reset
REQ-026 SHALL, with RST high at a clock edge, set the state to IDLE, is_chunk_ready=0, chunk_byte_size=0, chunk_bytes=0, is_overflow=0, count=0 and timer=0 from the next cycle, regardless of state.
REQ-027 SHALL discard any partial or held chunk on reset mid-operation and ignore rx_ready and chunk_ack in the reset cycle.
REQ-028 SHALL make the first byte after RST deasserts land in slot 0.

Verification
REQ-029 SHALL cover: defaults, bytes 0x41, 0x42, 0x43 on strobes spaced 10 cycles apart -> is_chunk_ready rises the cycle after 0x43, chunk_bytes=0x434241, chunk_byte_size=3; chunk_ack -> IDLE, outputs 0.
REQ-030 SHALL cover: TIMEOUT_TICKS=20, single byte 0x7F at cycle n -> is_chunk_ready at n+21, chunk_bytes=0x00007F, size=1; no assertion at n+20.
REQ-031 SHALL cover: chunk held in READY, extra byte 0x55 without ack -> is_overflow one cycle, chunk_bytes unchanged.
REQ-032 SHALL cover: in READY, chunk_ack and rx_ready(0x10) in the same cycle -> next cycle COLLECT, size=1, chunk_bytes=0x000010, no overflow.
REQ-033 SHALL cover: RST asserted after 2 of 3 bytes -> all outputs 0 next cycle; the following byte 0x99 lands in slot 0, size=1.
REQ-034 SHALL cover: TIMEOUT_TICKS=0, one byte then 10^4 idle cycles -> is_chunk_ready stays 0.
